// File: rtl/relay_contact_monitor.sv
// relay_contact_monitor
//   Closed-loop supervisor for a relay output path. The auxiliary contact-sense
//   input is synchronised and debounced. The debounced contact is then checked
//   against the commanded relay state, with a timeout on every commanded change.
//   A failure to close, a failure to open, or an unexpected contact change
//   latches a sticky fault. The fault stays latched until Fault_clr_i is pulsed.
//
// Parameters
//   DEBOUNCE_CYCLES_P  consecutive stable cycles before Contact_o changes
//   TIMEOUT_CYCLES_P   cycles allowed from command change to confirmed contact
//   CNT_WIDTH_P        counter width; holds TIMEOUT_CYCLES_P-1 and DEBOUNCE_CYCLES_P-1
//
// Ports
//   Clk_i         in   system clock
//   Reset_i       in   synchronous active-high reset
//   Relay_cmd_i   in   commanded relay state (1 = energise)
//   Contact_i     in   raw contact sense (1 = closed), asynchronous and bouncy
//   Fault_clr_i   in   single-cycle pulse that clears a latched fault
//   Contact_o     out  debounced contact state
//   Confirmed_o   out  1 while the contact matches the command (state OFF or ON)
//   Fault_o       out  sticky fault flag
//   Fault_code_o  out  00 none, 01 failed to close, 10 failed to open, 11 unexpected change

module relay_contact_monitor #(
   parameter int unsigned DEBOUNCE_CYCLES_P = 50000,
   parameter int unsigned TIMEOUT_CYCLES_P  = 1000000,
   parameter int unsigned CNT_WIDTH_P       = 20
) (
   input  logic       Clk_i,
   input  logic       Reset_i,
   input  logic       Relay_cmd_i,
   input  logic       Contact_i,
   input  logic       Fault_clr_i,
   output logic       Contact_o,
   output logic       Confirmed_o,
   output logic       Fault_o,
   output logic [1:0] Fault_code_o
);

   localparam logic [CNT_WIDTH_P-1:0] DebLast = CNT_WIDTH_P'(DEBOUNCE_CYCLES_P - 1);
   localparam logic [CNT_WIDTH_P-1:0] TmoLast = CNT_WIDTH_P'(TIMEOUT_CYCLES_P - 1);

   localparam logic [1:0] CodeNone      = 2'b00;
   localparam logic [1:0] CodeNoClose   = 2'b01;
   localparam logic [1:0] CodeNoOpen    = 2'b10;
   localparam logic [1:0] CodeUnexpect  = 2'b11;

   typedef enum logic [2:0] {
      StOff,
      StWaitClose,
      StOn,
      StWaitOpen,
      StFault
   } state_e;

   // Synchroniser: Contact_i feeds nothing but sync1_q.
   logic sync1_q, sync2_q;

   // Debouncer.
   logic                   contact_q, contact_d;
   logic [CNT_WIDTH_P-1:0] deb_cnt_q, deb_cnt_d;

   // Supervisor FSM and registered outputs.
   state_e                 state_q, state_d;
   logic [CNT_WIDTH_P-1:0] timer_q, timer_d;
   logic                   fault_q, fault_d;
   logic [1:0]             code_q, code_d;
   logic                   confirmed_q, confirmed_d;

   always_ff @(posedge Clk_i) begin
      if (Reset_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= Contact_i;
         sync2_q <= sync1_q;
      end
   end

   // Count consecutive cycles where the synchronised level disagrees with the
   // debounced output; any agreeing cycle restarts the count, so short glitches
   // never reach the terminal count.
   always_comb begin
      deb_cnt_d = '0;
      contact_d = contact_q;
      if (sync2_q != contact_q) begin
         if (deb_cnt_q == DebLast) begin
            contact_d = sync2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge Clk_i) begin
      if (Reset_i) begin
         contact_q <= 1'b0;
         deb_cnt_q <= '0;
      end else begin
         contact_q <= contact_d;
         deb_cnt_q <= deb_cnt_d;
      end
   end

   // Next-state logic. The FSM looks at the registered debounced contact, so a
   // contact change is acted on one edge after Contact_o moves.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      case (state_q)
         StOff: begin
            if (Relay_cmd_i) begin
               state_d = StWaitClose;
            end else if (contact_q) begin
               state_d = StFault;
               code_d  = CodeUnexpect;
            end
         end
         StWaitClose: begin
            if (!Relay_cmd_i) begin
               state_d = StWaitOpen;
            end else if (contact_q) begin
               state_d = StOn;
            end else if (timer_q == TmoLast) begin
               state_d = StFault;
               code_d  = CodeNoClose;
            end
         end
         StOn: begin
            if (!Relay_cmd_i) begin
               state_d = StWaitOpen;
            end else if (!contact_q) begin
               state_d = StFault;
               code_d  = CodeUnexpect;
            end
         end
         StWaitOpen: begin
            if (Relay_cmd_i) begin
               state_d = StWaitClose;
            end else if (!contact_q) begin
               state_d = StOff;
            end else if (timer_q == TmoLast) begin
               state_d = StFault;
               code_d  = CodeNoOpen;
            end
         end
         StFault: begin
            // Leaving FAULT always goes through a WAIT state so the contact is
            // re-verified under a fresh timeout.
            if (Fault_clr_i) begin
               state_d = Relay_cmd_i ? StWaitClose : StWaitOpen;
               code_d  = CodeNone;
            end
         end
         default: begin
            state_d = StOff;
            code_d  = CodeNone;
         end
      endcase

      if (state_d != state_q) begin
         timer_d = '0;
      end else if ((state_q == StWaitClose) || (state_q == StWaitOpen)) begin
         timer_d = timer_q + 1'b1;
      end else begin
         timer_d = '0;
      end

      fault_d     = (state_d == StFault);
      confirmed_d = (state_d == StOff) || (state_d == StOn);
   end

   always_ff @(posedge Clk_i) begin
      if (Reset_i) begin
         state_q     <= StOff;
         timer_q     <= '0;
         fault_q     <= 1'b0;
         code_q      <= CodeNone;
         confirmed_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         fault_q     <= fault_d;
         code_q      <= code_d;
         confirmed_q <= confirmed_d;
      end
   end

   assign Contact_o    = contact_q;
   assign Confirmed_o  = confirmed_q;
   assign Fault_o      = fault_q;
   assign Fault_code_o = code_q;

endmodule

// File: tb/tb_relay_contact_monitor.sv
// tb_relay_contact_monitor
//   Self-checking bench for relay_contact_monitor. A behavioural model tracks
//   the raw contact history and elapsed time in each waiting phase. Directed
//   scenarios and a randomized run are compared against that model every cycle.

module tb_relay_contact_monitor;

   localparam int D = 4;
   localparam int T = 20;

   logic       clk = 1'b0;
   logic       rst, cmd, raw, clr;
   logic       contact_o, confirmed_o, fault_o;
   logic [1:0] code_o;
   logic [4:0] dut_vec;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   relay_contact_monitor #(
      .DEBOUNCE_CYCLES_P (D),
      .TIMEOUT_CYCLES_P  (T),
      .CNT_WIDTH_P       (5)
   ) dut (
      .Clk_i        (clk),
      .Reset_i      (rst),
      .Relay_cmd_i  (cmd),
      .Contact_i    (raw),
      .Fault_clr_i  (clr),
      .Contact_o    (contact_o),
      .Confirmed_o  (confirmed_o),
      .Fault_o      (fault_o),
      .Fault_code_o (code_o)
   );

   assign dut_vec = {contact_o, confirmed_o, fault_o, code_o};

   // ---------------- behavioural reference model ----------------
   typedef enum int {MOff, MWaitClose, MOn, MWaitOpen, MFault} mphase_t;

   mphase_t  mph;
   int       cyc = 0;
   int       enter_cyc;
   int       since_flip;
   bit       m_contact, m_confirmed, m_fault;
   bit [1:0] m_code;
   bit       raw_hist[$];
   bit       used_hist[$];

   function automatic logic [4:0] exp_vec();
      return {m_contact, m_confirmed, m_fault, m_code};
   endfunction

   task automatic model_step();
      bit used;
      bit flip;
      cyc++;
      if (rst) begin
         mph = MOff; m_contact = 0; m_confirmed = 0; m_fault = 0; m_code = 0;
         raw_hist.delete(); used_hist.delete(); since_flip = 0;
         return;
      end
      // Supervisor rules, applied to the debounced contact as it stood before this edge.
      case (mph)
         MOff:
            if (cmd) begin mph = MWaitClose; enter_cyc = cyc; end
            else if (m_contact) begin mph = MFault; m_code = 2'b11; end
         MWaitClose:
            if (!cmd) begin mph = MWaitOpen; enter_cyc = cyc; end
            else if (m_contact) mph = MOn;
            else if (cyc - enter_cyc == T) begin mph = MFault; m_code = 2'b01; end
         MOn:
            if (!cmd) begin mph = MWaitOpen; enter_cyc = cyc; end
            else if (!m_contact) begin mph = MFault; m_code = 2'b11; end
         MWaitOpen:
            if (cmd) begin mph = MWaitClose; enter_cyc = cyc; end
            else if (!m_contact) mph = MOff;
            else if (cyc - enter_cyc == T) begin mph = MFault; m_code = 2'b10; end
         default:
            if (clr) begin
               mph = cmd ? MWaitClose : MWaitOpen;
               enter_cyc = cyc;
               m_code = 2'b00;
            end
      endcase
      m_fault     = (mph == MFault);
      m_confirmed = (mph == MOff) || (mph == MOn);
      // Debounce: the level seen at this edge is the raw level from two edges ago.
      // Contact flips once the last D seen levels since the previous flip all disagree.
      used = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 1'b0;
      raw_hist.push_back(raw);
      used_hist.push_back(used);
      since_flip++;
      if (since_flip >= D) begin
         flip = 1;
         for (int k = 1; k <= D; k++)
            if (used_hist[used_hist.size()-k] == m_contact) flip = 0;
         if (flip) begin
            m_contact  = !m_contact;
            since_flip = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1; cmd = 0; raw = 0; clr = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if (dut_vec !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_hold cyc=%0d got=%b want=%b", cyc, dut_vec, 5'b00000);
         end
      end
      rst = 0;
      tick();
      n_vec++;
      if (dut_vec !== 5'b01000) begin
         n_err++;
         $display("FAIL reset_release cyc=%0d got=%b want=%b", cyc, dut_vec, 5'b01000);
      end
   endtask

   task automatic test_close();
      cmd = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL close_wait cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec());
         end
      end
      raw = 1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         n_vec++;
         if (dut_vec !== {1'(i >= 6), 1'(i >= 7), 3'b000}) begin
            n_err++;
            $display("FAIL close_latency edge=%0d got=%b want=%b", i, dut_vec,
                     {1'(i >= 6), 1'(i >= 7), 3'b000});
         end
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL close_model cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_glitch();
      logic [6:0] pat;
      cmd = 0; raw = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL open_model cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec());
         end
      end
      pat = 7'b1101110;
      for (int i = 0; i < 13; i++) begin
         raw = (i < 7) ? pat[6-i] : 1'b0;
         tick();
         n_vec++;
         if (dut_vec !== 5'b01000) begin
            n_err++;
            $display("FAIL glitch_reject cyc=%0d got=%b want=%b", cyc, dut_vec, 5'b01000);
         end
      end
   endtask

   task automatic test_close_timeout();
      cmd = 1; raw = 0;
      for (int i = 1; i <= T + 1; i++) begin
         tick();
         n_vec++;
         if ({fault_o, code_o} !== ((i == T + 1) ? 3'b101 : 3'b000)) begin
            n_err++;
            $display("FAIL close_timeout edge=%0d got=%b want=%b", i, {fault_o, code_o},
                     (i == T + 1) ? 3'b101 : 3'b000);
         end
      end
      raw = 1;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL fault_hold cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec());
         end
      end
      clr = 1;
      tick();
      clr = 0;
      n_vec++;
      if (dut_vec !== 5'b10000) begin
         n_err++;
         $display("FAIL clear_close cyc=%0d got=%b want=%b", cyc, dut_vec, 5'b10000);
      end
      tick();
      n_vec++;
      if (dut_vec !== 5'b11000) begin
         n_err++;
         $display("FAIL reclose_on cyc=%0d got=%b want=%b", cyc, dut_vec, 5'b11000);
      end
   endtask

   task automatic test_unexpected_open();
      raw = 0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         n_vec++;
         if (dut_vec !== {1'(i < 6), 1'(i < 7), 1'(i >= 7), (i >= 7) ? 2'b11 : 2'b00}) begin
            n_err++;
            $display("FAIL unexpected_open edge=%0d got=%b want=%b", i, dut_vec,
                     {1'(i < 6), 1'(i < 7), 1'(i >= 7), (i >= 7) ? 2'b11 : 2'b00});
         end
      end
      cmd = 0; clr = 1;
      tick();
      clr = 0;
      n_vec++;
      if (dut_vec !== 5'b00000) begin
         n_err++;
         $display("FAIL clear_open cyc=%0d got=%b want=%b", cyc, dut_vec, 5'b00000);
      end
      tick();
      n_vec++;
      if (dut_vec !== 5'b01000) begin
         n_err++;
         $display("FAIL reopen_off cyc=%0d got=%b want=%b", cyc, dut_vec, 5'b01000);
      end
   endtask

   task automatic test_reset_mid_wait();
      cmd = 1; raw = 1;
      for (int i = 0; i < 10; i++) tick();
      n_vec++;
      if (dut_vec !== 5'b11000) begin
         n_err++;
         $display("FAIL pre_wait_on cyc=%0d got=%b want=%b", cyc, dut_vec, 5'b11000);
      end
      cmd = 0;
      for (int i = 0; i < 11; i++) begin
         tick();
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL wait_open_model cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec());
         end
      end
      rst = 1;
      tick();
      rst = 0; raw = 0;
      n_vec++;
      if (dut_vec !== 5'b00000) begin
         n_err++;
         $display("FAIL reset_mid_wait cyc=%0d got=%b want=%b", cyc, dut_vec, 5'b00000);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         n_vec++;
         if (dut_vec !== 5'b01000) begin
            n_err++;
            $display("FAIL after_reset cyc=%0d got=%b want=%b", cyc, dut_vec, 5'b01000);
         end
      end
   endtask

   task automatic test_open_timeout();
      cmd = 1; raw = 1;
      for (int i = 0; i < 10; i++) tick();
      cmd = 0;
      for (int i = 1; i <= T + 1; i++) begin
         tick();
         n_vec++;
         if ({fault_o, code_o} !== ((i == T + 1) ? 3'b110 : 3'b000)) begin
            n_err++;
            $display("FAIL open_timeout edge=%0d got=%b want=%b", i, {fault_o, code_o},
                     (i == T + 1) ? 3'b110 : 3'b000);
         end
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL open_timeout_model cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      bit lvl;
      lvl = raw;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(24, 0) == 0) cmd = !cmd;
         if ($urandom_range(29, 0) == 0) lvl = !lvl;
         raw = ($urandom_range(7, 0) == 0) ? !lvl : lvl;
         clr = ($urandom_range(14, 0) == 0);
         rst = ($urandom_range(199, 0) == 0);
         tick();
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL random cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec());
         end
      end
      rst = 0; clr = 0;
   endtask

   initial begin
      test_reset();
      test_close();
      test_glitch();
      test_close_timeout();
      test_unexpected_open();
      test_reset_mid_wait();
      test_open_timeout();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
